// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: mode FSM encoding and CPU run-state values.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_LOAD   = 2'b00,
    ARB_SWITCH = 2'b01,
    ARB_RUN    = 2'b10
  } arb_state_e;

  localparam logic CPU_IDLE = 1'b0;
  localparam logic CPU_EXEC = 1'b1;

endpackage

// File: rtl/mem_arbiter_age_counter.sv
// Saturating count of consecutive denied fetch cycles; sat lets fetch override data.
module arb_age_counter #(
  parameter int MAX_WAIT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment so a grant in a saturated cycle restarts from 0.
  always_ff @(posedge clock) begin
    if (!reset || i_clr)               r_cnt <= '0;
    else if (i_inc && (r_cnt != MAX_V)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified memory: loader owns it while the CPU is idle,
// fetch/data share it while executing, with a one-cycle SWITCH gap between modes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_state,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              l_rvalid,
  output logic              d_rvalid,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e r_state, w_state_nxt;
  logic       w_sat, w_run, w_load;
  logic       r_l_rvalid, r_d_rvalid, r_i_rvalid;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ARB_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_LOAD:   if (cpu_state == CPU_EXEC) w_state_nxt = ARB_SWITCH;
      ARB_SWITCH: w_state_nxt = (cpu_state == CPU_EXEC) ? ARB_RUN : ARB_LOAD;
      ARB_RUN:    if (cpu_state == CPU_IDLE) w_state_nxt = ARB_SWITCH;
      default:    w_state_nxt = ARB_LOAD;
    endcase
  end

  // Grants are gated by reset so nothing touches memory during a reset cycle.
  assign w_load = reset && (r_state == ARB_LOAD);
  assign w_run  = reset && (r_state == ARB_RUN);

  always_comb begin
    l_gnt = 1'b0;
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (w_load) begin
      l_gnt = l_req;
    end else if (w_run) begin
      if (i_req && (w_sat || !d_req)) i_gnt = 1'b1;
      else                            d_gnt = d_req;
    end
  end

  arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clock (clock),
    .reset (reset),
    .i_inc (w_run && i_req && !i_gnt),
    .i_clr (!w_run || !i_req || i_gnt),
    .o_sat (w_sat)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  assign mem_en = l_gnt | d_gnt | i_gnt;

  // Read completions are tagged by owner; they are independent of the mode FSM so a
  // read granted just before SWITCH still returns to its requester.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_l_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
    end else begin
      r_l_rvalid <= l_gnt && !l_we;
      r_d_rvalid <= d_gnt && !d_we;
      r_i_rvalid <= i_gnt;
    end
  end

  assign l_rvalid = r_l_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rvalid = r_i_rvalid;
  assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and mode model.
module tb_mem_arbiter;
  localparam int AW = 8, DW = 16, MW = 3;

  logic clock = 1'b0, reset = 1'b0, cpu_state = 1'b0;
  logic l_req = 0, l_we = 0, d_req = 0, d_we = 0, i_req = 0;
  logic [AW-1:0] l_addr = '0, d_addr = '0, i_addr = '0;
  logic [DW-1:0] l_wdata = '0, d_wdata = '0;
  logic l_gnt, d_gnt, i_gnt, l_rvalid, d_rvalid, i_rvalid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .cpu_state(cpu_state),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .l_rvalid(l_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory device attached to the arbiter (one-cycle read latency).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [2:0] own; logic [DW-1:0] data; int due; } exp_t;
  exp_t q[$];

  // Reference: mode is 0=load,1=switch,2=run; m_wait counts denied fetch cycles.
  int m_mode = 0, m_wait = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic el, ed, ei;
    logic [AW-1:0] ea;
    el = 0; ed = 0; ei = 0; ea = '0;
    if (reset) begin
      if (m_mode == 0) el = l_req;
      else if (m_mode == 2) begin
        if (d_req && i_req) begin
          if (m_wait == MW) ei = 1; else ed = 1;
        end else begin
          ed = d_req; ei = i_req;
        end
      end
    end
    chk("gnt_lDi", {29'd0, l_gnt, d_gnt, i_gnt}, {29'd0, el, ed, ei});
    chk("mem_en", {31'd0, mem_en}, {31'd0, el | ed | ei});
    chk("rdata_pass", {16'd0, rdata}, {16'd0, mem_rdata});
    if (el) begin
      chk("mem_we_l", {31'd0, mem_we}, {31'd0, l_we});
      chk("mem_addr_l", {24'd0, mem_addr}, {24'd0, l_addr});
      ea = l_addr;
      if (l_we) begin
        chk("mem_wdata_l", {16'd0, mem_wdata}, {16'd0, l_wdata});
        ref_mem[l_addr] = l_wdata;
      end else q.push_back('{3'b100, ref_mem[ea], cyc + 1});
    end else if (ed) begin
      chk("mem_we_d", {31'd0, mem_we}, {31'd0, d_we});
      chk("mem_addr_d", {24'd0, mem_addr}, {24'd0, d_addr});
      ea = d_addr;
      if (d_we) begin
        chk("mem_wdata_d", {16'd0, mem_wdata}, {16'd0, d_wdata});
        ref_mem[d_addr] = d_wdata;
      end else q.push_back('{3'b010, ref_mem[ea], cyc + 1});
    end else if (ei) begin
      chk("mem_we_i", {31'd0, mem_we}, 32'd0);
      chk("mem_addr_i", {24'd0, mem_addr}, {24'd0, i_addr});
      q.push_back('{3'b001, ref_mem[i_addr], cyc + 1});
    end else begin
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    if (!reset) begin
      m_mode = 0; m_wait = 0;
    end else begin
      if (m_mode == 2 && i_req && !ei) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else m_wait = 0;
      if (m_mode == 1) m_mode = cpu_state ? 2 : 0;
      else if (m_mode == 0 && cpu_state) m_mode = 1;
      else if (m_mode == 2 && !cpu_state) m_mode = 1;
    end
  end

  // Monitor: pops the oldest expected read whenever any rvalid is presented.
  always @(negedge clock) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid_missing cyc=%0d owner=%b expected_due=%0d", cyc, q[0].own, q[0].due);
      void'(q.pop_front());
    end
    if (l_rvalid | d_rvalid | i_rvalid) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected cyc=%0d actual=%b required=000", cyc, {l_rvalid, d_rvalid, i_rvalid});
      end else begin
        chk("rvalid_owner", {29'd0, l_rvalid, d_rvalid, i_rvalid}, {29'd0, q[0].own});
        chk("rdata", {16'd0, rdata}, {16'd0, q[0].data});
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic rand_cycle();
    logic sl, sd, si;
    @(negedge clock);
    sl = l_gnt; sd = d_gnt; si = i_gnt;
    @(posedge clock); #1;
    if (!l_req || sl) begin
      l_req = ($urandom_range(3) != 0); l_we = 1'($urandom_range(1));
      l_addr = 8'($urandom_range(31)); l_wdata = 16'($urandom);
    end else if ($urandom_range(15) == 0) l_req = 0;
    if (!d_req || sd) begin
      d_req = ($urandom_range(2) != 0); d_we = 1'($urandom_range(1));
      d_addr = 8'($urandom_range(31)); d_wdata = 16'($urandom);
    end else if ($urandom_range(15) == 0) d_req = 0;
    if (!i_req || si) begin
      i_req = ($urandom_range(3) != 0); i_addr = 8'($urandom_range(31));
    end else if ($urandom_range(15) == 0) i_req = 0;
    if ($urandom_range(19) == 0) cpu_state = ~cpu_state;
    reset = ($urandom_range(149) != 0);
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin mem[k] = '0; ref_mem[k] = '0; end
    // Reset with a loader request pending: must not be granted.
    l_req = 1; l_we = 1; l_addr = 8'h33; l_wdata = 16'h1234;
    step(3);
    reset = 1;
    l_req = 1; l_we = 1; l_addr = 8'h10; l_wdata = 16'hBEEF; step();
    l_we = 0; step();
    l_req = 0; step();
    // Switch to run with a fetch held.
    i_req = 1; i_addr = 8'h10; cpu_state = 1; step(3);
    i_req = 0; step();
    // Contention and a blocked loader.
    l_req = 1; l_we = 1; d_req = 1; d_we = 0; d_addr = 8'h10; i_req = 1; i_addr = 8'h10;
    step(10);
    // D read in last run cycle, then back to load.
    i_req = 0; d_req = 1; d_we = 0; cpu_state = 0; step();
    d_req = 0; l_we = 0; l_addr = 8'h10; step(3);
    l_req = 0;
    // Reset right after a D read grant.
    cpu_state = 1; step(2);
    d_req = 1; step();
    d_req = 0; reset = 0; l_req = 1; step(2);
    reset = 1; l_req = 0; cpu_state = 0; step(2);
    // Fast cpu_state toggling.
    l_req = 1; d_req = 1; i_req = 1;
    repeat (8) begin cpu_state = ~cpu_state; step(); end
    for (int n = 0; n < 4000; n++) rand_cycle();
    l_req = 0; d_req = 0; i_req = 0;
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory between three requesters: the CPU instruction fetch port (I), the CPU data access port (D), and the external program loader (L). The arbiter follows the run/idle state produced by the CPU control FSM. The loader owns memory only while the CPU is idle; fetch and data ports share it while the CPU executes. A one-cycle switch state separates the two modes so an in-flight read always completes to its original owner.

## Interface
- ADDR_W, 8, memory word address width
- DATA_W, 16, memory word width (matches 16-bit instruction)
- MAX_WAIT, 3, consecutive denied fetch cycles before I overrides D (≥1)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; clears all state on the edge where low
- cpu_state  in  1  CPU run state from CPU control (`idle`=0, `exec`=1)
- l_req, l_we  in  1  loader request / write enable
- l_addr  in  ADDR_W; l_wdata  in  DATA_W
- l_gnt  out  1  loader granted this cycle
- d_req, d_we  in  1  data port request / write enable
- d_addr  in  ADDR_W; d_wdata  in  DATA_W
- d_gnt  out  1  data port granted this cycle
- i_req  in  1  fetch request (read only); i_addr  in  ADDR_W
- i_gnt  out  1  fetch granted this cycle
- l_rvalid, d_rvalid, i_rvalid  out  1  read data valid for that owner
- rdata  out  DATA_W  shared read data, equals mem_rdata
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  memory read data, one-cycle latency

## Operation
- Mode FSM, 3 states: LOAD (reset state), SWITCH, RUN.
  - LOAD: only L is grantable. cpu_state=1 → SWITCH.
  - SWITCH: no grants, mem_en=0. cpu_state=1 → RUN, else → LOAD.
  - RUN: only I/D are grantable. cpu_state=0 → SWITCH.
- Grant is combinational from the current state and req: at most one gnt per cycle. Only a granted port drives mem_* (addr, wdata, we=req_we; I always we=0). mem_en=|gnt.
- RUN priority: D over I, except I wins when wait_cnt==MAX_WAIT.
- wait_cnt: increments (saturating at MAX_WAIT) on each RUN cycle with i_req=1 and i_gnt=0. Clears on i_gnt, on i_req=0, or outside RUN.
- Read completion: on a granted read (gnt&~we), the matching *_rvalid is set for exactly the next cycle. Write grants produce no rvalid.
- A requester holds req/addr/wdata stable until it sees gnt. Dropping req before gnt is legal; nothing is issued.
- Requests to a port not grantable in the current state are held off indefinitely and are not errors.
- The mode switch never suppresses a pending rvalid: a read granted in RUN/LOAD in the cycle before SWITCH still returns rvalid during SWITCH.

## Timing
- Grant latency: 0 cycles (same cycle as req when eligible). Write commits at that edge.
- Read latency: rvalid and rdata valid 1 cycle after gnt.
- cpu_state edge → first grant in the new mode: 2 cycles (SWITCH occupies 1).
- Throughput: one access per cycle in LOAD/RUN.
- Reset values: state=LOAD, wait_cnt=0, all *_rvalid=0. All gnt and mem_en/mem_we are 0 during reset cycle. rdata follows mem_rdata.
- Reset mid-operation: a pending rvalid is dropped (0 on the cycle after the reset edge). Grants are blocked while reset is low.
- Simultaneous D and I with wait_cnt==MAX_WAIT: I granted and wait_cnt→0.
- cpu_state toggling every cycle: FSM alternates LOAD/RUN↔SWITCH and never grants in SWITCH.

## Structure
- Add to define.v: ARB_LOAD=2'b00, ARB_SWITCH=2'b01, ARB_RUN=2'b10. Reuse existing `idle`/`exec`.
- One sub-module, arb_age_counter: saturating wait counter (MAX_WAIT parameter, inc/clr inputs, sat output).
- Top level holds the mode FSM, grant/priority logic, mem mux and rvalid registers.

## Test plan
- Reset, cpu_state=0, L write addr 8'h10 data 16'hBEEF → l_gnt=1, mem_en=1, mem_we=1, mem_addr=8'h10 same cycle. L read 8'h10 → l_rvalid=1 next cycle, rdata=16'hBEEF.
- cpu_state 0→1 sampled at edge t with i_req=1 held → cycle t+1 SWITCH, i_gnt=0, mem_en=0. Cycle t+2 i_gnt=1.
- RUN, MAX_WAIT=3, d_req and i_req held high → grant sequence D,D,D,I repeating. wait_cnt reads 0,1,2,3,0.
- RUN, l_req=1 for 10 cycles → l_gnt stays 0. I read 8'h10 → i_rvalid next cycle, rdata=16'hBEEF.
- D read granted in last RUN cycle, cpu_state→0 → d_rvalid=1 during SWITCH. l_gnt=0 in SWITCH, 1 in the following LOAD cycle.
- Reset low in cycle after a D read grant → d_rvalid=0 next cycle, state LOAD, no grants while reset low.
